// File: rtl/aes_mode_ctrl_pkg.sv
// aes_mode_ctrl_pkg: shared constants, mode and FSM encodings for the AES mode controller
package aes_mode_ctrl_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [2:0] {
        MODE_ECB_E = 3'd0,
        MODE_ECB_D = 3'd1,
        MODE_CBC_E = 3'd2,
        MODE_CBC_D = 3'd3,
        MODE_CTR   = 3'd4
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KEY  = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_e;

    function automatic logic mode_ok(logic [2:0] m);
        return m <= 3'd4;
    endfunction

    function automatic logic mode_dec(mode_e m);
        return m == MODE_ECB_D || m == MODE_CBC_D;
    endfunction

endpackage

// File: rtl/aes_mode_ctrl_blk_fifo.sv
// aes_blk_fifo: 128-bit block FIFO with full/empty/count, pushes while full are dropped
module aes_blk_fifo
    import aes_mode_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [BLK_W-1:0]       din,
    output logic [BLK_W-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BLK_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rp];

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= do_push ? wp + AW'(1) : wp;
            rp    <= do_pop ? rp + AW'(1) : rp;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB/CBC/CTR block-mode sequencer around external AES encrypt/decrypt cores
module aes_mode_ctrl
    import aes_mode_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CTR_W = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [2:0]       Mode,
    input  logic [BLK_W-1:0] Key,
    input  logic             Krdy,
    input  logic [BLK_W-1:0] IV,
    input  logic             IVrdy,
    input  logic [BLK_W-1:0] Din,
    input  logic             Drdy,
    output logic [BLK_W-1:0] Dout,
    output logic             Dvld,
    output logic             Dfull,
    output logic             BSY,
    output logic             ERR,
    output logic [BLK_W-1:0] C_Din,
    output logic [BLK_W-1:0] C_Key,
    output logic             C_Drdy,
    output logic             C_Krdy,
    output logic             C_EN,
    output logic             C_DEC,
    input  logic [BLK_W-1:0] C_Dout,
    input  logic             C_BSY,
    input  logic             C_Dvld
);

    localparam logic [BLK_W-1:0] CTR_MASK = (BLK_W'(1) << CTR_W) - BLK_W'(1);

    state_e                  state;
    state_e                  state_nx;
    mode_e                   mode_q;
    logic                    key_vld;
    logic [BLK_W-1:0]        ch;
    logic [BLK_W-1:0]        h;
    logic [BLK_W-1:0]        dout_q;
    logic [BLK_W-1:0]        din_q;
    logic [BLK_W-1:0]        key_q;
    logic                    dvld_q;
    logic                    err_q;
    logic                    drdy_q;
    logic                    krdy_q;
    logic                    en_q;
    logic [BLK_W-1:0]        f_head;
    logic                    f_full;
    logic                    f_empty;
    logic [$clog2(DEPTH):0]  f_count;
    logic                    key_go;
    logic                    blk_go;
    logic                    res_go;
    logic                    err_set;
    logic [BLK_W-1:0]        core_in;
    logic [BLK_W-1:0]        res;
    logic [BLK_W-1:0]        ch_upd;

    aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RSTn),
        .push  (Drdy),
        .pop   (blk_go),
        .din   (Din),
        .head  (f_head),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign Dout   = dout_q;
    assign Dvld   = dvld_q;
    assign Dfull  = f_full;
    assign BSY    = state != S_IDLE || f_count != '0;
    assign ERR    = err_q;
    assign C_Din  = din_q;
    assign C_Key  = key_q;
    assign C_Drdy = drdy_q;
    assign C_Krdy = krdy_q;
    assign C_EN   = en_q;
    assign C_DEC  = mode_dec(mode_q);

    // Start conditions, error detection and the mode-dependent data paths
    always_comb begin
        key_go  = state == S_IDLE && Krdy && mode_ok(Mode);
        blk_go  = state == S_IDLE && !Krdy && key_vld && !f_empty;
        res_go  = state == S_WAIT && C_Dvld;
        err_set = (Krdy && (state != S_IDLE || !mode_ok(Mode)))
                || (IVrdy && state != S_IDLE)
                || (Drdy && f_full);
        core_in = mode_q == MODE_CBC_E ? f_head ^ ch :
                  mode_q == MODE_CTR   ? ch : f_head;
        res     = mode_q == MODE_CBC_D ? C_Dout ^ ch :
                  mode_q == MODE_CTR   ? C_Dout ^ h : C_Dout;
        ch_upd  = mode_q == MODE_CBC_E ? C_Dout :
                  mode_q == MODE_CBC_D ? h :
                  mode_q == MODE_CTR   ? (ch & ~CTR_MASK) | ((ch + BLK_W'(1)) & CTR_MASK) : ch;
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // FSM next state; KEY ignores C_BSY while the key strobe is still out
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = key_go ? S_KEY : blk_go ? S_LOAD : S_IDLE;
            S_KEY:   state_nx = (!krdy_q && !C_BSY) ? S_IDLE : S_KEY;
            S_LOAD:  state_nx = S_WAIT;
            S_WAIT:  state_nx = C_Dvld ? S_OUT : S_WAIT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered core strobes, key/mode, chain value, result and error flag
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mode_q  <= MODE_ECB_E;
            key_vld <= 1'b0;
            key_q   <= '0;
            krdy_q  <= 1'b0;
            drdy_q  <= 1'b0;
            din_q   <= '0;
            h       <= '0;
            ch      <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            en_q    <= 1'b1;
            krdy_q  <= key_go;
            drdy_q  <= blk_go;
            dvld_q  <= res_go;
            err_q   <= err_q | err_set;
            if (key_go) begin
                mode_q  <= mode_e'(Mode);
                key_q   <= Key;
                key_vld <= 1'b1;
            end
            if (blk_go) begin
                h     <= f_head;
                din_q <= core_in;
            end
            if (res_go) begin
                dout_q <= res;
                ch     <= ch_upd;
            end else if (state == S_IDLE && IVrdy) begin
                ch <= IV;
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: directed vector bench with a known-answer stub core of latency 3
module tb_aes_mode_ctrl;
    import aes_mode_ctrl_pkg::*;

    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KD = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int NV = 8;

    typedef struct {
        logic [2:0]   mode;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] din;
        logic [127:0] cdin;
        logic [127:0] dout;
        logic         dec;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic [2:0]   Mode = '0;
    logic [127:0] Key = '0;
    logic         Krdy = 1'b0;
    logic [127:0] IV = '0;
    logic         IVrdy = 1'b0;
    logic [127:0] Din = '0;
    logic         Drdy = 1'b0;
    logic [127:0] Dout;
    logic         Dvld;
    logic         Dfull;
    logic         BSY;
    logic         ERR;
    logic [127:0] C_Din;
    logic [127:0] C_Key;
    logic         C_Drdy;
    logic         C_Krdy;
    logic         C_EN;
    logic         C_DEC;
    logic [127:0] C_Dout;
    logic         C_BSY;
    logic         C_Dvld;

    logic [127:0] m_key;
    logic [127:0] m_din;
    logic         m_dec;
    logic [1:0]   kbusy;
    logic [1:0]   cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;
    int last_push = 0;
    logic [127:0] oq[$];
    int           ocyc[$];
    logic [127:0] dq[$];
    logic         decq[$];
    vec_t tv[NV];

    aes_mode_ctrl #(.DEPTH(4), .CTR_W(32)) dut (
        .CLK(CLK), .RSTn(RSTn), .Mode(Mode), .Key(Key), .Krdy(Krdy),
        .IV(IV), .IVrdy(IVrdy), .Din(Din), .Drdy(Drdy),
        .Dout(Dout), .Dvld(Dvld), .Dfull(Dfull), .BSY(BSY), .ERR(ERR),
        .C_Din(C_Din), .C_Key(C_Key), .C_Drdy(C_Drdy), .C_Krdy(C_Krdy),
        .C_EN(C_EN), .C_DEC(C_DEC), .C_Dout(C_Dout), .C_BSY(C_BSY), .C_Dvld(C_Dvld)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Stub core: real AES answers for the two known vectors, key xor data otherwise
    function automatic logic [127:0] core_f(logic dec, logic [127:0] k, logic [127:0] x);
        if (!dec && k == K && x == P) return C;
        if (dec && k == KD && x == C) return P;
        return x ^ k;
    endfunction

    assign C_BSY = kbusy != 2'd0 || cnt != 2'd0;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_key  <= '0;
            m_din  <= '0;
            m_dec  <= 1'b0;
            kbusy  <= '0;
            cnt    <= '0;
            C_Dvld <= 1'b0;
            C_Dout <= '0;
        end else begin
            C_Dvld <= 1'b0;
            kbusy  <= C_Krdy ? 2'd2 : (kbusy != 2'd0 ? kbusy - 2'd1 : 2'd0);
            if (C_Krdy) m_key <= C_Key;
            if (C_Drdy) begin
                m_din <= C_Din;
                m_dec <= C_DEC;
                cnt   <= 2'd2;
            end else if (cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
                if (cnt == 2'd1) begin
                    C_Dvld <= 1'b1;
                    C_Dout <= core_f(m_dec, m_key, m_din);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (Dvld) begin
            oq.push_back(Dout);
            ocyc.push_back(cyc);
        end
        if (C_Drdy) begin
            dq.push_back(C_Din);
            decq.push_back(C_DEC);
        end
        if (C_Drdy && C_Krdy) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr_q();
        oq.delete();
        ocyc.delete();
        dq.delete();
        decq.delete();
    endtask

    task automatic wait_idle(string nm);
        int t = 0;
        while (BSY && t < 150) begin
            tick();
            t++;
        end
        if (BSY) begin
            checks++;
            errors++;
            $display("FAIL %s: BSY still 1 after %0d cycles, required 0", nm, t);
        end
    endtask

    task automatic load_key(logic [2:0] m, logic [127:0] k);
        Mode = m;
        Key  = k;
        Krdy = 1'b1;
        tick();
        Krdy = 1'b0;
        wait_idle("key_wait");
    endtask

    task automatic load_iv(logic [127:0] v);
        IV    = v;
        IVrdy = 1'b1;
        tick();
        IVrdy = 1'b0;
    endtask

    task automatic push(logic [127:0] v);
        Din       = v;
        Drdy      = 1'b1;
        last_push = cyc;
        tick();
        Drdy      = 1'b0;
    endtask

    task automatic wait_out(int n);
        int t = 0;
        while (oq.size() < n && t < 150) begin
            tick();
            t++;
        end
        if (oq.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_out: got %0d Dvld strobes, required %0d", oq.size(), n);
        end
        tick(2);
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        tick();
        clr_q();
    endtask

    initial begin
        tv[0] = '{3'd0, K,  '0,           P,            P,           C, 1'b0};
        tv[1] = '{3'd1, KD, '0,           C,            C,           P, 1'b1};
        tv[2] = '{3'd2, K,  P,            '0,           P,           C, 1'b0};
        tv[3] = '{3'd3, KD, P,            C,            C,           '0, 1'b1};
        tv[4] = '{3'd4, K,  P,            '0,           P,           C, 1'b0};
        tv[5] = '{3'd3, KD, 128'h1,       '0,           '0,
                  128'h13111d7fe3944a17f307a78b4d2b30c4, 1'b1};
        tv[6] = '{3'd4, K,  '0,           128'hff,      '0,
                  128'h000102030405060708090a0b0c0d0ef0, 1'b0};
        tv[7] = '{3'd2, K,  128'hf0,      128'h0f,      128'hff,
                  128'h000102030405060708090a0b0c0d0ef0, 1'b0};

        #2;
        chk("rst_c_en", 128'(C_EN), 0);
        chk("rst_dout", Dout, 0);
        chk("rst_dvld", 128'(Dvld), 0);
        chk("rst_bsy", 128'(BSY), 0);
        chk("rst_err", 128'(ERR), 0);
        chk("rst_ckrdy", 128'(C_Krdy), 0);
        tick();
        RSTn = 1'b1;
        tick();
        chk("run_c_en", 128'(C_EN), 1);

        push(P);
        tick(20);
        chk("nokey_no_dvld", 128'(oq.size()), 0);
        chk("nokey_bsy", 128'(BSY), 1);
        load_key(3'd0, K);
        wait_out(1);
        if (oq.size() > 0) chk("nokey_then_key_dout", oq[0], C);

        for (int i = 0; i < NV; i++) begin
            clr_q();
            load_key(tv[i].mode, tv[i].key);
            load_iv(tv[i].iv);
            push(tv[i].din);
            wait_out(1);
            if (oq.size() > 0) begin
                chk($sformatf("v%0d_dout", i), oq[0], tv[i].dout);
                chk($sformatf("v%0d_latency", i), 128'(ocyc[0] - last_push), 6);
            end
            if (dq.size() > 0) begin
                chk($sformatf("v%0d_cdin", i), dq[0], tv[i].cdin);
                chk($sformatf("v%0d_cdec", i), 128'(decq[0]), 128'(tv[i].dec));
            end
        end
        chk("vec_err_clean", 128'(ERR), 0);

        clr_q();
        load_key(3'd2, K);
        load_iv(P);
        push('0);
        push(C);
        wait_out(2);
        if (oq.size() > 1) begin
            chk("cbc_dout0", oq[0], C);
            chk("cbc_dout1", oq[1], K);
        end
        if (dq.size() > 1) chk("cbc_cdin1", dq[1], '0);

        clr_q();
        load_key(3'd4, K);
        load_iv(P);
        push('0);
        push('0);
        wait_out(2);
        if (oq.size() > 0) chk("ctr_dout0", oq[0], C);
        if (dq.size() > 1) chk("ctr_cdin1", dq[1], 128'h00112233445566778899aabbccddef00);
        clr_q();
        load_iv(128'h00112233445566778899aabbffffffff);
        push('0);
        push('0);
        wait_out(2);
        if (dq.size() > 1) begin
            chk("ctr_wrap_cdin0", dq[0], 128'h00112233445566778899aabbffffffff);
            chk("ctr_wrap_cdin1", dq[1], 128'h00112233445566778899aabb00000000);
        end
        chk("ctr_err_clean", 128'(ERR), 0);

        load_key(3'd5, K);
        chk("reserved_mode_err", 128'(ERR), 1);
        do_reset();
        chk("reset_clears_err", 128'(ERR), 0);

        Mode = 3'd0;
        Key  = K;
        Krdy = 1'b1;
        tick();
        Krdy  = 1'b0;
        IV    = P;
        IVrdy = 1'b1;
        tick();
        IVrdy = 1'b0;
        wait_idle("iv_err_wait");
        chk("iv_outside_idle_err", 128'(ERR), 1);
        do_reset();

        for (int i = 1; i <= 5; i++) push(128'(i));
        chk("stress_dfull", 128'(Dfull), 1);
        chk("stress_err", 128'(ERR), 1);
        load_key(3'd0, K);
        wait_out(4);
        chk("stress_count", 128'(oq.size()), 4);
        for (int i = 0; i < 4 && i < oq.size(); i++)
            chk($sformatf("stress_order%0d", i), oq[i], 128'(i + 1) ^ K);

        do_reset();
        load_key(3'd0, K);
        clr_q();
        push(P);
        tick(2);
        RSTn = 1'b0;
        #2;
        chk("wait_rst_bsy", 128'(BSY), 0);
        chk("wait_rst_err", 128'(ERR), 0);
        tick();
        RSTn = 1'b1;
        tick(12);
        chk("wait_rst_no_dvld", 128'(oq.size()), 0);
        load_key(3'd0, K);
        push(P);
        wait_out(1);
        if (oq.size() > 0) chk("after_rst_dout", oq[0], C);

        chk("krdy_drdy_exclusive", 128'(overlap), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_mode_ctrl.md
AES_MODE_CTRL -- requirements
Module: aes_mode_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: input block FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter CTR_W, default 32: CTR-mode counter width, occupying the low bits of the 128-bit IV, 8..128.
REQ-003 SHALL have ports, in order:
  CLK  in  1  single clock, rising edge.
  RSTn  in  1  reset, asynchronous, active-low.
  Mode  in  3  0 ECB-E, 1 ECB-D, 2 CBC-E, 3 CBC-D, 4 CTR; 5-7 reserved.
  Key  in  128  key; for decrypt modes, the final encryption round key.
  Krdy  in  1  pulse: latch Key and Mode.
  IV  in  128  chain/counter initial value.
  IVrdy  in  1  pulse: latch IV.
  Din  in  128  data block.
  Drdy  in  1  pulse: push Din into the FIFO.
  Dout  out  128  result block.
  Dvld  out  1  one-cycle strobe: Dout is valid.
  Dfull  out  1  FIFO holds DEPTH blocks.
  BSY  out  1  FSM is not in IDLE, or the FIFO is non-empty.
  ERR  out  1  sticky error flag.
  C_Din  out  128  core data input.
  C_Key  out  128  core key input.
  C_Drdy  out  1  core data strobe.
  C_Krdy  out  1  core key strobe.
  C_EN  out  1  core enable.
  C_DEC  out  1  1 selects the decrypt core.
  C_Dout  in  128  core result.
  C_BSY  in  1  core busy.
  C_Dvld  in  1  core result strobe.

Function
REQ-004 SHALL implement FSM states IDLE, KEY, LOAD, WAIT and OUT.
REQ-005 In IDLE, Krdy with a valid Mode SHALL latch Key and Mode, drive C_Krdy=1 for one cycle with C_Key=Key, and go to KEY.
REQ-006 Krdy with a reserved Mode, or Krdy outside IDLE, SHALL be ignored and SHALL set ERR.
REQ-007 KEY SHALL remain until C_BSY=0 is sampled, no earlier than the cycle after C_Krdy, then go to IDLE.
REQ-008 IVrdy SHALL load the chain register CH in IDLE only; IVrdy in any other state SHALL be ignored and SHALL set ERR.
REQ-009 In IDLE with the FIFO non-empty and no Krdy, the FSM SHALL go to LOAD; Krdy has priority over starting a block.
REQ-010 LOAD SHALL pop the FIFO head into register H and drive C_Drdy=1 for one cycle, then go to WAIT.
REQ-011 In LOAD, C_Din SHALL be H in ECB and CBC-D, H xor CH in CBC-E, and CH in CTR.
REQ-012 WAIT SHALL capture C_Dout when C_Dvld=1 and go to OUT.
REQ-013 OUT SHALL drive Dvld=1 for one cycle with Dout equal to C_Dout in ECB and CBC-E, C_Dout xor CH in CBC-D, and C_Dout xor H in CTR.
REQ-014 OUT SHALL update CH as follows: CBC-E, CH<=C_Dout; CBC-D, CH<=H; CTR, low CTR_W bits of CH increment modulo 2^CTR_W with the upper bits unchanged; ECB, CH unchanged. The FSM then goes to IDLE.
REQ-015 Dout SHALL hold its value between Dvld strobes.
REQ-016 Latency from FIFO non-empty in IDLE to Dvld SHALL be L+2 cycles, where L is the core's C_Drdy-to-C_Dvld latency.
REQ-017 Drdy with Dfull=1 SHALL be dropped and SHALL set ERR, even if a pop occurs in the same cycle.
REQ-018 A push and a pop in the same cycle when not full SHALL leave the FIFO count unchanged.
REQ-019 FIFO order SHALL be strict FIFO.
REQ-020 C_DEC SHALL be 1 for Mode 1 and Mode 3 and 0 otherwise; C_EN SHALL be 1 outside reset.
REQ-021 C_Drdy and C_Krdy SHALL never be asserted in the same cycle.

Reset
REQ-022 RSTn=0 SHALL immediately force the FSM to IDLE and empty the FIFO.
REQ-023 RSTn=0 SHALL clear CH, H, the Key/Mode registers, Dout, ERR, Dvld, C_Drdy, C_Krdy, C_Din, C_Key and C_EN to zero.
REQ-024 After reset, the key register SHALL be invalid and FIFO blocks SHALL NOT start until a Krdy is accepted.
REQ-025 Reset mid-operation SHALL discard the in-flight block with no Dvld; the core shares RSTn.

Structure
REQ-026 A shared package SHALL hold the Mode encodings, the FSM state encoding and the block width constant of 128.
REQ-027 The FIFO SHALL be one sub-module, aes_blk_fifo (parameter DEPTH, 128-bit data, full/empty/count).
REQ-028 The AES cores SHALL stay external to this module.

Verification (AES_ENC/AES_DEC cores attached; K=000102030405060708090a0b0c0d0e0f, KD=13111d7fe3944a17f307a78b4d2b30c5, P=00112233445566778899aabbccddeeff, C=69c4e0d86a7b0430d8cdb78070b4c55a)
REQ-029 ECB-E: Key K, push P -> one Dvld with Dout=C, L+2 cycles after the push.
REQ-030 ECB-D: Key KD, push C -> Dout=P.
REQ-031 CBC-E: IV=P, push 0 -> Dout=C; then push C -> the core input is C xor C = 0, and CH=C afterwards.
REQ-032 CTR (CTR_W=32): IV=P, push 0 then 0 -> first Dout=C; CH low word goes ccddeeff -> ccddef00; an IV whose low word is ffffffff wraps it to 00000000 with the upper 96 bits unchanged.
REQ-033 FIFO stress: DEPTH+1 back-to-back Drdy -> Dfull asserted, last block dropped, ERR=1, exactly DEPTH Dvld in push order.
REQ-034 Reset during WAIT -> no Dvld, BSY=0, ERR=0; a subsequent Krdy plus block completes correctly.
